// File: rtl/noc_switch_pkg.sv
// Shared constants for the NoC distribute/reduce switch family.
package noc_switch_pkg;

    // Switch command encodings
    localparam logic [1:0] CMD_COLLECT     = 2'b00;
    localparam logic [1:0] CMD_BRANCH_LOW  = 2'b01;
    localparam logic [1:0] CMD_BRANCH_HIGH = 2'b10;
    localparam logic [1:0] CMD_REDUCE      = 2'b11;

    // Lane indices within the 2-bit valid/ready vectors
    localparam int LANE_LOW  = 0;
    localparam int LANE_HIGH = 1;

    // All-zero word driven when no real data is present
    localparam logic [63:0] DUMMY_DATA = 64'h0;

endpackage : noc_switch_pkg

// File: rtl/reduce_out_fifo2.sv
// Two-entry register queue feeding the switch output. Slot 0 is always the
// head; vacated slots are cleared so the output word is zero when empty.
module reduce_out_fifo2
    import noc_switch_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [1:0]            count,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data
);

    localparam logic [DATA_WIDTH-1:0] DUMMY_WORD = DATA_WIDTH'(DUMMY_DATA);

    logic [DATA_WIDTH-1:0] slot0_r;
    logic [DATA_WIDTH-1:0] slot1_r;
    logic [1:0]            count_r;
    logic [DATA_WIDTH-1:0] slot0_s;
    logic [DATA_WIDTH-1:0] slot1_s;
    logic [1:0]            count_s;
    logic                  pop_ok_s;
    logic                  push_ok_s;

    // Qualify requests: never pop empty, never push into a full queue that is not draining
    always_comb begin
        pop_ok_s  = pop && (count_r != 2'd0);
        push_ok_s = push && ((count_r != 2'd2) || pop_ok_s);
    end

    // Next-state of the slots and occupancy for every push/pop combination
    always_comb begin
        slot0_s = slot0_r;
        slot1_s = slot1_r;
        count_s = count_r;
        case (count_r)
            2'd0: begin
                if (push_ok_s) begin
                    slot0_s = push_data;
                    count_s = 2'd1;
                end else begin
                    count_s = 2'd0;
                end
            end
            2'd1: begin
                case ({push_ok_s, pop_ok_s})
                    2'b10: begin
                        slot1_s = push_data;
                        count_s = 2'd2;
                    end
                    2'b01: begin
                        slot0_s = DUMMY_WORD;
                        count_s = 2'd0;
                    end
                    2'b11: begin
                        slot0_s = push_data;
                        count_s = 2'd1;
                    end
                    default: begin
                        count_s = 2'd1;
                    end
                endcase
            end
            2'd2: begin
                case ({push_ok_s, pop_ok_s})
                    2'b01: begin
                        slot0_s = slot1_r;
                        slot1_s = DUMMY_WORD;
                        count_s = 2'd1;
                    end
                    2'b11: begin
                        slot0_s = slot1_r;
                        slot1_s = push_data;
                        count_s = 2'd2;
                    end
                    default: begin
                        count_s = 2'd2;
                    end
                endcase
            end
            default: begin
                // Unreachable occupancy: flush back to empty
                slot0_s = DUMMY_WORD;
                slot1_s = DUMMY_WORD;
                count_s = 2'd0;
            end
        endcase
    end

    // Queue storage and occupancy registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot0_r <= DUMMY_WORD;
            slot1_r <= DUMMY_WORD;
            count_r <= 2'd0;
        end else begin
            slot0_r <= slot0_s;
            slot1_r <= slot1_s;
            count_r <= count_s;
        end
    end

    assign count     = count_r;
    assign out_valid = (count_r != 2'd0);
    assign out_data  = slot0_r;

endmodule : reduce_out_fifo2

// File: rtl/reduce_switch_seq.sv
// Two-to-one collect/reduce switch: forwards one lane, round-robins between
// lanes, or adds them, and buffers the result in a 2-entry output queue.
module reduce_switch_seq
    import noc_switch_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [1:0]              i_valid,
    input  logic [2*DATA_WIDTH-1:0] i_data_bus,
    output logic [1:0]              o_ready,
    input  logic                    i_en,
    input  logic [1:0]              i_cmd,
    output logic                    o_valid,
    output logic [DATA_WIDTH-1:0]   o_data_bus,
    input  logic                    i_ready
);

    localparam logic [DATA_WIDTH-1:0] DUMMY_WORD = DATA_WIDTH'(DUMMY_DATA);

    logic [DATA_WIDTH-1:0] lane_low_s;
    logic [DATA_WIDTH-1:0] lane_high_s;
    logic [DATA_WIDTH-1:0] sum_s;
    logic [1:0]            count_s;
    logic                  fifo_valid_s;
    logic [DATA_WIDTH-1:0] fifo_data_s;
    logic                  pop_s;
    logic                  can_push_s;
    logic [1:0]            ready_s;
    logic                  push_s;
    logic [DATA_WIDTH-1:0] push_data_s;
    logic                  grant_high_s;
    logic                  collect_push_s;
    logic                  rr_ptr_r;

    assign lane_low_s  = i_data_bus[DATA_WIDTH-1:0];
    assign lane_high_s = i_data_bus[2*DATA_WIDTH-1:DATA_WIDTH];
    // Partial sums wrap; the carry out is intentionally discarded
    assign sum_s       = lane_low_s + lane_high_s;

    // Queue space is available if not full, or if the head leaves this cycle
    always_comb begin
        pop_s      = fifo_valid_s && i_ready;
        can_push_s = i_en && ((count_s != 2'd2) || pop_s);
    end

    // Collect-mode arbitration: a lone valid lane wins, a tie goes to rr_ptr
    always_comb begin
        if (i_valid[LANE_HIGH] && i_valid[LANE_LOW]) begin
            grant_high_s = rr_ptr_r;
        end else if (i_valid[LANE_HIGH]) begin
            grant_high_s = 1'b1;
        end else begin
            grant_high_s = 1'b0;
        end
    end

    // Command decode: per-lane accept, push strobe and pushed word
    always_comb begin
        ready_s        = 2'b00;
        push_s         = 1'b0;
        push_data_s    = DUMMY_WORD;
        collect_push_s = 1'b0;
        case (i_cmd)
            CMD_BRANCH_LOW: begin
                ready_s     = {1'b0, can_push_s};
                push_s      = can_push_s && i_valid[LANE_LOW];
                push_data_s = lane_low_s;
            end
            CMD_BRANCH_HIGH: begin
                ready_s     = {can_push_s, 1'b0};
                push_s      = can_push_s && i_valid[LANE_HIGH];
                push_data_s = lane_high_s;
            end
            CMD_REDUCE: begin
                // Both operands must be present; a lone lane is held off
                ready_s     = {2{can_push_s && i_valid[LANE_HIGH] && i_valid[LANE_LOW]}};
                push_s      = ready_s[LANE_LOW];
                push_data_s = sum_s;
            end
            CMD_COLLECT: begin
                if (can_push_s && (i_valid != 2'b00)) begin
                    ready_s        = grant_high_s ? 2'b10 : 2'b01;
                    push_s         = 1'b1;
                    collect_push_s = 1'b1;
                    push_data_s    = grant_high_s ? lane_high_s : lane_low_s;
                end else begin
                    ready_s = 2'b00;
                end
            end
            default: begin
                ready_s = 2'b00;
            end
        endcase
    end

    // Round-robin pointer: after a collect push, prefer the lane that lost
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_r <= 1'b0;
        end else if (collect_push_s) begin
            rr_ptr_r <= ~grant_high_s;
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

    reduce_out_fifo2 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_out_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push_s),
        .push_data  (push_data_s),
        .pop        (pop_s),
        .count      (count_s),
        .out_valid  (fifo_valid_s),
        .out_data   (fifo_data_s)
    );

    // Accept is held off while reset is asserted so no lane sees a handshake
    assign o_ready    = rst_n ? ready_s : 2'b00;
    assign o_valid    = fifo_valid_s;
    assign o_data_bus = fifo_data_s;

endmodule : reduce_switch_seq
